// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Requester indices, the zero word and small index helpers used by the
// arbiter top and its grant picker.
package regfile_wb_arbiter_pkg;

  // Fixed requester slots on the writeback bus.
  localparam int WB_REQ_ALU = 0;
  localparam int WB_REQ_LSU = 1;

  // Register address and data widths of the core's register file.
  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;

  localparam logic [REG_W-1:0] ZERO_WORD = '0;

  // Next index after idx in a ring of n slots.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // Upward distance from pointer p to slot i in a ring of n slots.
  function automatic int ring_dist(input int i, input int p, input int n);
    return (i >= p) ? i - p : i + n - p;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_picker.sv
// Grant picker for the writeback arbiter (module wb_rr_picker).
// Turns a request vector and a start pointer into a one-hot grant: the
// valid requester closest to the pointer (walking upward, wrapping) wins.
// A constant-zero pointer gives plain lowest-index-first priority.
module wb_rr_picker
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  int best;

  // Smallest distance from the pointer among valid requesters.
  always_comb begin
    best = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && (ring_dist(i, int'(ptr), N_REQ) < best)) begin
        best = ring_dist(i, int'(ptr), N_REQ);
      end
    end
  end

  // Grant exactly the requester at that distance; distances are unique so
  // at most one bit is set, and never without its request.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = req[i] && (ring_dist(i, int'(ptr), N_REQ) == best);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard.
// Shares the single regfile write port among N_REQ writeback requesters
// (one grant per cycle, write port registered) and tracks one busy bit per
// architectural register for ID-stage hazard stalls.
// Configuration macro WBARB_ROUND_ROBIN_EN: defined -> round-robin grant
// order; undefined -> fixed priority, lowest requester index wins.
//
// Handshake: a requester holds req_valid/addr/data stable until its
// req_ready bit is 1; a transfer happens in the cycle valid && ready.
// req_ready is combinational, one-hot or zero, and is zero during reset.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  input  logic                      flush,
  output logic                      we,
  output logic [ADDR_W-1:0]         waddr,
  output logic [DATA_W-1:0]         wdata,
  output logic [(1<<ADDR_W)-1:0]    busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NREG  = 1 << ADDR_W;

  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  rr_ptr;
  logic              any_grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   busy_next;

  wb_rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

`ifdef WBARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] next_ptr;

  // Pointer moves one past the granted requester; held when nothing granted.
  always_comb begin
    next_ptr = rr_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        next_ptr = PTR_W'(wrap_inc(i, N_REQ));
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= next_ptr;
    end
  end
`else
  // Search always starts at requester 0: lowest index wins.
  assign rr_ptr = '0;
`endif

  // Nothing is accepted while reset is held.
  assign req_ready = rst ? '0 : grant;
  assign any_grant = |grant;

  // Steer the granted requester's address and data onto the write path.
  always_comb begin
    sel_addr = '0;
    sel_data = ZERO_WORD[DATA_W-1:0];
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Registered write port: one-cycle latency from acceptance. A grant to x0
  // is consumed but writes nothing; idle cycles hold waddr/wdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (any_grant && (sel_addr != '0)) begin
      we    <= 1'b1;
      waddr <= sel_addr;
      wdata <= sel_data;
    end else begin
      we    <= 1'b0;
    end
  end

  // Scoreboard update: commit clears, issue sets (set applied last so a
  // newer producer stays pending), flush clears everything, x0 never busy.
  always_comb begin
    busy_next = busy;
    if (we) begin
      busy_next[waddr] = 1'b0;
    end
    if (issue_valid && (issue_addr != '0)) begin
      busy_next[issue_addr] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// Reference model: requester-level arbitration (first valid requester at or
// after the model pointer), a list of expected register writes with the
// cycle they must appear, and a per-register pending array.
module tb_regfile_wb_arbiter;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREG   = 1 << ADDR_W;
  localparam int EW     = 16 + ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    issue_valid;
  logic [ADDR_W-1:0]       issue_addr;
  logic                    flush;
  logic                    we;
  logic [ADDR_W-1:0]       waddr;
  logic [DATA_W-1:0]       wdata;
  logic [NREG-1:0]         busy;

  regfile_wb_arbiter #(
    .N_REQ  (N_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .flush       (flush),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .busy        (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];   // {due_cycle[15:0], addr, data}
  logic mon_en = 1'b0;

  // reference model
  logic [NREG-1:0]   busy_m;
  logic              m_we;
  logic [ADDR_W-1:0] m_waddr;
  int                m_ptr;
  int                last_g;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  // Pops the expected write due this cycle; otherwise the port must be idle.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      logic [EW-1:0] e;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        if (int'(e[EW-1 -: 16]) == cyc) begin
          check("commit_we", 64'(we), 64'(1));
          check("commit_waddr", 64'(waddr), 64'(e[DATA_W +: ADDR_W]));
          check("commit_wdata", 64'(wdata), 64'(e[DATA_W-1:0]));
          void'(exp_q.pop_front());
        end else if (int'(e[EW-1 -: 16]) < cyc) begin
          check("commit_missed", 64'(0), 64'(1));
          void'(exp_q.pop_front());
        end else begin
          check("idle_we", 64'(we), 64'(0));
        end
      end else begin
        check("idle_we", 64'(we), 64'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_clear();
    busy_m  = '0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_ptr   = 0;
    last_g  = -1;
    exp_q.delete();
  endtask

  task automatic set_idle();
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    flush       = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_valid[i] = 1'b1;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle: called at a negedge with inputs already applied.
  task automatic step();
    int g;
    int start;
    logic [N_REQ-1:0]  exp_ready;
    logic [ADDR_W-1:0] ga;
    logic [DATA_W-1:0] gd;
    logic [NREG-1:0]   nb;
    #1;
    start = 0;
`ifdef WBARB_ROUND_ROBIN_EN
    start = m_ptr;
`endif
    g = -1;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (start + k) % N_REQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    exp_ready = '0;
    ga = '0;
    gd = '0;
    if (g >= 0) begin
      exp_ready[g] = 1'b1;
      ga = req_addr[g*ADDR_W +: ADDR_W];
      gd = req_data[g*DATA_W +: DATA_W];
      if (ga != 0) exp_q.push_back({16'(cyc + 1), ga, gd});
    end
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    // scoreboard rules: commit clears, newer issue wins, flush wipes all
    nb = busy_m;
    if (m_we) nb[m_waddr] = 1'b0;
    if (issue_valid && issue_addr != 0) nb[issue_addr] = 1'b1;
    if (flush) nb = '0;
    @(posedge clk);
    busy_m  = nb;
    m_we    = (g >= 0) && (ga != 0);
    if (m_we) m_waddr = ga;
    if (g >= 0) m_ptr = (g + 1) % N_REQ;
    last_g = g;
    @(negedge clk);
    check("busy", 64'(busy), 64'(busy_m));
  endtask

  // ---------------- stimulus ----------------
  logic [N_REQ-1:0]  pend;
  logic [ADDR_W-1:0] pa [N_REQ];
  logic [DATA_W-1:0] pd [N_REQ];

  initial begin
    set_idle();
    model_clear();

    // reset holds ready low even with both requests valid
    req_valid = 2'b11;
    #3;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_we", 64'(we), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    set_idle();
    do_reset();
    mon_en = 1'b1;

    // single write from the ALU slot
    set_req(0, 5'd5, 32'hDEADBEEF);
    step();
    set_idle();
    step();

    // both requesters valid for three cycles
    for (int n = 0; n < 3; n++) begin
      set_req(0, 5'd1, $urandom);
      set_req(1, 5'd2, $urandom);
      step();
    end
    set_idle();
    step();

    // write to x0 is consumed with no register write
    set_req(1, 5'd0, 32'h1);
    step();
    set_idle();
    step();
    check("x0_busy", 64'(busy[0]), 64'(0));

    // issue x7, write it back two cycles later, then repeat with a
    // re-issue on the commit edge
    for (int rep = 0; rep < 2; rep++) begin
      issue_valid = 1'b1;
      issue_addr  = 5'd7;
      step();
      set_idle();
      step();
      set_req(0, 5'd7, $urandom);
      step();
      set_idle();
      if (rep == 1) begin
        issue_valid = 1'b1;
        issue_addr  = 5'd7;
      end
      step();
      set_idle();
      step();
      check("x7_busy_after", 64'(busy[7]), 64'(rep));
    end

    // flush against a same-edge issue while a write is in flight
    issue_valid = 1'b1; issue_addr = 5'd3;
    step();
    issue_addr = 5'd9;
    step();
    set_idle();
    set_req(1, 5'd12, 32'hCAFE0012);
    step();
    set_idle();
    flush = 1'b1; issue_valid = 1'b1; issue_addr = 5'd4;
    step();
    set_idle();
    check("flush_busy", 64'(busy), 64'(0));
    step();

    // asynchronous reset while a write is on the port
    issue_valid = 1'b1; issue_addr = 5'd6;
    set_req(0, 5'd6, 32'h0BAD0006);
    step();
    set_idle();
    #1;
    check("pre_rst_we", 64'(we), 64'(1));
    rst = 1'b1;
    #1;
    check("async_rst_we", 64'(we), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_ready", 64'(req_ready), 64'(0));
    do_reset();

    // randomized traffic with holding requesters
    pend = '0;
    for (int n = 0; n < 400; n++) begin
      set_idle();
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pa[i] = ADDR_W'($urandom_range(0, 9));
          pd[i] = $urandom;
        end
        if (pend[i]) set_req(i, pa[i], pd[i]);
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_addr  = ADDR_W'($urandom_range(0, 9));
      flush       = ($urandom_range(0, 40) == 0);
      step();
      if (last_g >= 0) pend[last_g] = 1'b0;
    end

    set_idle();
    repeat (3) step();
    check("drain", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
